ray_stepper_scheduler: RTL and testbench

Shares one `RayStepper` instance between N ray requesters (ray generators / shading units) in the ray-marching pipeline.
- Round-robin arbitration picks the next request and latches its ray and box into registers.
- It pulses the stepper's `start`, holds operands stable for the whole operation and waits for `done`, with a watchdog timeout.
- The result goes out on a single tagged response channel.

---
 rtl/ray_stepper_scheduler_pkg.sv | 15 +
 rtl/ray_stepper_scheduler_arbiter.sv | 33 +++
 rtl/ray_stepper_scheduler.sv | 147 ++++++++++++++
 tb/tb_ray_stepper_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_stepper_scheduler_pkg.sv
// Shared types for the ray stepper scheduler: operand vector type and FSM states.
package ray_pkg;

   localparam int VEC_W = 16;

   typedef logic [2:0][VEC_W-1:0] vec3_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } sched_state_t;

endpackage

// File: rtl/ray_stepper_scheduler_arbiter.sv
// Combinational round-robin arbiter; the search begins one past the last winner and wraps.
module round_robin_arbiter #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] pointer_i,
   input  logic           enable_i,
   output logic [N-1:0]   grant_o,
   output logic [IDW-1:0] index_o
);

   localparam int unsigned NU = N;

   logic           found;
   logic [IDW-1:0] cidx;

   always_comb begin
      grant_o = '0;
      index_o = '0;
      found   = 1'b0;
      cidx    = '0;
      for (int unsigned k = 1; k <= NU; k++) begin
         cidx = IDW'((32'(pointer_i) + k) % NU);
         if (enable_i && !found && req_i[cidx]) begin
            found         = 1'b1;
            grant_o[cidx] = 1'b1;
            index_o       = cidx;
         end
      end
   end

endmodule

// File: rtl/ray_stepper_scheduler.sv
// Shares one RayStepper between N requesters: RR grant, start pulse, watchdog, tagged response.
module ray_stepper_scheduler #(
   parameter  int WIDTH   = 16,
   parameter  int N       = 4,
   parameter  int TIMEOUT = 1023,
   localparam int IDW     = $clog2(N)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N-1:0]                 req_valid,
   output logic [N-1:0]                 req_ready,
   input  logic [N-1:0][2:0][WIDTH-1:0] req_q,
   input  logic [N-1:0][2:0][WIDTH-1:0] req_v,
   input  logic [N-1:0][2:0][WIDTH-1:0] req_l,
   input  logic [N-1:0][2:0][WIDTH-1:0] req_u,
   output logic                         st_start,
   output logic [2:0][WIDTH-1:0]        st_q,
   output logic [2:0][WIDTH-1:0]        st_v,
   output logic [2:0][WIDTH-1:0]        st_l,
   output logic [2:0][WIDTH-1:0]        st_u,
   input  logic                         st_done,
   input  logic                         st_outOfBounds,
   input  logic [2:0][WIDTH-1:0]        st_vp,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [IDW-1:0]               rsp_id,
   output logic [2:0][WIDTH-1:0]        rsp_vp,
   output logic                         rsp_oob,
   output logic                         rsp_timeout,
   output logic                         busy
);
   import ray_pkg::*;

   localparam int CW = $clog2(TIMEOUT + 1);

   sched_state_t          state_q, state_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2:0][WIDTH-1:0] q_q, q_d, v_q, v_d, l_q, l_d, u_q, u_d;
   logic [2:0][WIDTH-1:0] vp_q, vp_d;
   logic                  oob_q, oob_d;
   logic                  to_q, to_d;

   logic [N-1:0]          grant;
   logic [IDW-1:0]        gidx;

   round_robin_arbiter #(.N(N)) u_arb (
      .req_i     (req_valid),
      .pointer_i (ptr_q),
      .enable_i  (state_q == IDLE),
      .grant_o   (grant),
      .index_o   (gidx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      v_d     = v_q;
      l_d     = l_q;
      u_d     = u_q;
      vp_d    = vp_q;
      oob_d   = oob_q;
      to_d    = to_q;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               q_d     = req_q[gidx];
               v_d     = req_v[gidx];
               l_d     = req_l[gidx];
               u_d     = req_u[gidx];
               id_d    = gidx;
               ptr_d   = gidx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // done has priority over a watchdog expiry in the same cycle
            if (st_done) begin
               vp_d    = st_vp;
               oob_d   = st_outOfBounds;
               to_d    = 1'b0;
               state_d = RESPOND;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               vp_d    = '0;
               oob_d   = 1'b1;
               to_d    = 1'b1;
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(N - 1);
         id_q    <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         v_q     <= '0;
         l_q     <= '0;
         u_q     <= '0;
         vp_q    <= '0;
         oob_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         v_q     <= v_d;
         l_q     <= l_d;
         u_q     <= u_d;
         vp_q    <= vp_d;
         oob_q   <= oob_d;
         to_q    <= to_d;
      end
   end

   assign req_ready   = grant;
   assign st_start    = (state_q == ISSUE);
   assign st_q        = q_q;
   assign st_v        = v_q;
   assign st_l        = l_q;
   assign st_u        = u_q;
   assign rsp_valid   = (state_q == RESPOND);
   assign rsp_id      = id_q;
   assign rsp_vp      = vp_q;
   assign rsp_oob     = oob_q;
   assign rsp_timeout = to_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ray_stepper_scheduler.sv
// Bench for ray_stepper_scheduler: timestamp-based transaction model plus directed scenarios.
module tb_ray_stepper_scheduler;
   import ray_pkg::*;

   localparam int W   = 16;
   localparam int N   = 4;
   localparam int TO  = 16;
   localparam int IDW = 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [N-1:0]             req_valid, req_ready;
   logic [N-1:0][2:0][W-1:0] req_q, req_v, req_l, req_u;
   logic                     st_start, st_done, st_outOfBounds;
   vec3_t                    st_q, st_v, st_l, st_u, st_vp, rsp_vp;
   logic                     rsp_valid, rsp_ready, rsp_oob, rsp_timeout, busy;
   logic [IDW-1:0]           rsp_id;

   ray_stepper_scheduler #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_q          (req_q),
      .req_v          (req_v),
      .req_l          (req_l),
      .req_u          (req_u),
      .st_start       (st_start),
      .st_q           (st_q),
      .st_v           (st_v),
      .st_l           (st_l),
      .st_u           (st_u),
      .st_done        (st_done),
      .st_outOfBounds (st_outOfBounds),
      .st_vp          (st_vp),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_id         (rsp_id),
      .rsp_vp         (rsp_vp),
      .rsp_oob        (rsp_oob),
      .rsp_timeout    (rsp_timeout),
      .busy           (busy)
   );

   // Behavioural stepper: done pulses stp_delay cycles after the start cycle (0 = never).
   int    stp_delay;
   vec3_t stp_vp;
   logic  stp_oob;
   logic  sd_model = 1'b0;
   logic  sd_force;
   int    done_at  = -1;
   assign st_done        = sd_model | sd_force;
   assign st_vp          = stp_vp;
   assign st_outOfBounds = stp_oob;

   int pend [N];
   always_comb begin
      req_valid = '0;
      for (int i = 0; i < N; i++) if (pend[i] > 0) req_valid[i] = 1'b1;
   end

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // Model: one ray in flight, described by the cycle it was started and the cycle its response appears.
   int    cyc        = 0;
   bit    model_ok   = 1'b0;
   bit    m_busy     = 1'b0;
   int    m_ptr, m_id, m_start_at, m_rsp_at;
   vec3_t m_q, m_v, m_l, m_u, m_vp;
   bit    m_oob, m_to;
   logic  st_start_smp;
   logic [N-1:0] rdy_smp;

   always @(negedge clock) begin
      st_start_smp = st_start;
      rdy_smp      = req_ready;
   end

   always @(posedge clock) begin
      int k;
      logic [N-1:0] hs;
      hs = '0;
      if (!reset) begin
         m_busy = 1'b0; m_ptr = N - 1; m_id = 0; m_start_at = -1; m_rsp_at = -1;
         m_q = '0; m_v = '0; m_l = '0; m_u = '0; m_vp = '0; m_oob = 1'b0; m_to = 1'b0;
         done_at = -1; model_ok = 1'b1;
      end else begin
         if (!m_busy) begin
            k = rr_pick(req_valid, m_ptr);
            if (k >= 0) begin
               m_busy = 1'b1; m_ptr = k; m_id = k;
               m_q = req_q[k]; m_v = req_v[k]; m_l = req_l[k]; m_u = req_u[k];
               m_start_at = cyc + 1; m_rsp_at = -1;
            end
         end else if (m_rsp_at < 0) begin
            if (cyc > m_start_at && st_done === 1'b1) begin
               m_rsp_at = cyc + 1; m_vp = st_vp; m_oob = st_outOfBounds; m_to = 1'b0;
            end else if (cyc == m_start_at + TO) begin
               m_rsp_at = cyc + 1; m_vp = '0; m_oob = 1'b1; m_to = 1'b1;
            end
         end else if (rsp_ready) begin
            m_busy = 1'b0;
         end
         if (st_start_smp === 1'b1) done_at = (stp_delay > 0) ? cyc + stp_delay : -1;
         hs = req_valid & rdy_smp;
      end
      cyc++;
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) pend[i]--;
      sd_model = (cyc == done_at);
   end

   always @(negedge clock) begin
      logic [N-1:0] er;
      int k;
      bit ev;
      if (model_ok) begin
         er = '0;
         if (!m_busy) begin
            k = rr_pick(req_valid, m_ptr);
            if (k >= 0) er[k] = 1'b1;
         end
         ev = m_busy && m_rsp_at >= 0 && cyc >= m_rsp_at;
         check("req_ready", req_ready, er);
         check("busy", busy, m_busy);
         check("st_start", st_start, m_busy && cyc == m_start_at);
         check("rsp_valid", rsp_valid, ev);
         if (ev) check("rsp_id", rsp_id, m_id);
         check("rsp_vp", rsp_vp, m_vp);
         check("rsp_oob", rsp_oob, m_oob);
         check("rsp_timeout", rsp_timeout, m_to);
         check("st_q", st_q, m_q);
         check("st_v", st_v, m_v);
         check("st_l", st_l, m_l);
         check("st_u", st_u, m_u);
      end
   end

   task automatic sync();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_rsp(output int cs, output int cr);
      cs = -1;
      cr = -1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clock);
         if (st_start && cs < 0) cs = cyc;
         if (rsp_valid) begin
            cr = cyc;
            break;
         end
      end
      if (cr < 0) begin
         n_vec++; n_fail++;
         $display("FAIL rsp_wait: no response within 100 cycles, expected one");
      end
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 300; t++) begin
         @(negedge clock);
         if (!busy && req_valid == '0) return;
      end
      n_vec++; n_fail++;
      $display("FAIL idle_wait: still busy after 300 cycles, expected idle");
   endtask

   initial begin
      #200000;
      $display("FAIL global_watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int g, cs, cr, cnt;
      int gq[$];
      int iq[$];
      int order[8];
      order = '{0, 1, 2, 3, 0, 1, 2, 3};
      reset = 1'b0; rsp_ready = 1'b1; sd_force = 1'b0;
      stp_delay = 2; stp_vp = '0; stp_oob = 1'b0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0;
         for (int j = 0; j < 3; j++) begin
            req_q[i][j] = W'(100 * i + j + 1);
            req_v[i][j] = W'(200 * i + j + 5);
            req_l[i][j] = W'(300 * i + j + 7);
            req_u[i][j] = W'(400 * i + j + 9);
         end
      end
      req_q[2] = {16'd30, 16'd20, 16'd10};
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;

      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_st_start", st_start, 0);
      check("rst_st_q", st_q, 0);

      // Fairness: every requester holds two rays.
      sync();
      stp_delay = 2; stp_vp = {16'd3, 16'd2, 16'd1};
      for (int i = 0; i < N; i++) pend[i] = 2;
      for (int t = 0; t < 400 && (gq.size() < 8 || iq.size() < 8); t++) begin
         @(negedge clock);
         for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) gq.push_back(i);
         if (rsp_valid && rsp_ready) iq.push_back(int'(rsp_id));
      end
      check("fair_grants", gq.size(), 8);
      check("fair_rsps", iq.size(), 8);
      for (int i = 0; i < 8 && i < gq.size(); i++) check($sformatf("fair_grant%0d", i), gq[i], order[i]);
      for (int i = 0; i < 8 && i < iq.size(); i++) check($sformatf("fair_rsp_id%0d", i), iq[i], order[i]);
      wait_idle();

      // Single request, stepper done 5 cycles after start.
      sync();
      stp_delay = 5; stp_vp = {16'd30, 16'd20, 16'd40}; stp_oob = 1'b0;
      g = cyc; pend[2] = 1;
      wait_rsp(cs, cr);
      check("single_start_lat", cs - g, 1);
      check("single_rsp_lat", cr - g, 7);
      check("single_id", rsp_id, 2);
      check("single_vp", rsp_vp, {16'd30, 16'd20, 16'd40});
      check("single_oob", rsp_oob, 0);
      check("single_st_q", st_q, {16'd30, 16'd20, 16'd10});
      wait_idle();

      // Backpressure: consumer stalls for 10 cycles.
      sync();
      rsp_ready = 1'b0; stp_delay = 3; stp_vp = {16'd7, 16'd8, 16'd9}; stp_oob = 1'b1;
      pend[1] = 1; pend[3] = 1;
      wait_rsp(cs, cr);
      check("bp_first_id", rsp_id, 3);
      for (int t = 0; t < 10; t++) begin
         @(negedge clock);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_vp", rsp_vp, {16'd7, 16'd8, 16'd9});
         check("bp_req_ready", req_ready, 0);
         check("bp_st_start", st_start, 0);
      end
      rsp_ready = 1'b1;
      wait_rsp(cs, cr);
      check("bp_second_id", rsp_id, 1);
      wait_idle();

      // Watchdog: stepper never finishes.
      sync();
      stp_delay = 0; stp_oob = 1'b0; stp_vp = {16'd3, 16'd2, 16'd1};
      pend[0] = 1;
      wait_rsp(cs, cr);
      check("to_lat", cr - cs, 17);
      check("to_flag", rsp_timeout, 1);
      check("to_vp", rsp_vp, 0);
      check("to_oob", rsp_oob, 1);
      wait_idle();
      sync();
      stp_delay = 4; stp_oob = 1'b1; stp_vp = {16'd13, 16'd12, 16'd11};
      pend[1] = 1;
      wait_rsp(cs, cr);
      check("after_to_lat", cr - cs, 5);
      check("after_to_flag", rsp_timeout, 0);
      check("after_to_vp", rsp_vp, {16'd13, 16'd12, 16'd11});
      wait_idle();

      // done arrives on the last watchdog cycle.
      sync();
      stp_delay = 16; stp_oob = 1'b0; stp_vp = {16'd23, 16'd22, 16'd21};
      pend[2] = 1;
      wait_rsp(cs, cr);
      check("edge_lat", cr - cs, 17);
      check("edge_flag", rsp_timeout, 0);
      check("edge_vp", rsp_vp, {16'd23, 16'd22, 16'd21});
      wait_idle();

      // Stale done during the issue cycle.
      sync();
      stp_delay = 6; stp_vp = {16'd33, 16'd32, 16'd31};
      g = cyc; pend[3] = 1;
      sync();
      sd_force = 1'b1;
      sync();
      sd_force = 1'b0;
      wait_rsp(cs, cr);
      check("stale_lat", cr - g, 8);
      check("stale_vp", rsp_vp, {16'd33, 16'd32, 16'd31});
      check("stale_flag", rsp_timeout, 0);
      wait_idle();

      // Reset pulse while waiting on the stepper.
      sync();
      stp_delay = 10; pend[1] = 1;
      repeat (4) sync();
      reset = 1'b0;
      sync();
      reset = 1'b1;
      @(negedge clock);
      check("rst2_busy", busy, 0);
      check("rst2_rsp_valid", rsp_valid, 0);
      check("rst2_rsp_vp", rsp_vp, 0);
      check("rst2_st_q", st_q, 0);
      check("rst2_rsp_id", rsp_id, 0);
      cnt = 0;
      for (int t = 0; t < 15; t++) begin
         @(negedge clock);
         if (rsp_valid) cnt++;
      end
      check("rst2_no_rsp", cnt, 0);
      sync();
      pend[2] = 1; pend[0] = 1;
      @(negedge clock);
      check("rst2_first_grant", req_ready, 4'b0001);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
